load_store_unit: RTL

//   Sits between the core's MEM stage and the word-organised dual-port data RAM that replaces
//   the byte-array data memory. Accepts one RV32I load/store per handshake and converts it to

---
 rtl/rv32i_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 36 +++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store width codes, LSU state encoding and
// helpers for access-size decoding.
package rv32i_pkg;

  localparam logic [2:0] F3_BYTE  = 3'd0;
  localparam logic [2:0] F3_HALF  = 3'd1;
  localparam logic [2:0] F3_WORD  = 3'd2;
  localparam logic [2:0] F3_UBYTE = 3'd4;
  localparam logic [2:0] F3_UHALF = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_LO,
    LSU_HI,
    LSU_DONE
  } lsu_state_e;

  // Byte-lane mask of an access before alignment; 0 marks an illegal width.
  function automatic logic [3:0] size_mask(input logic [2:0] func3);
    case (func3)
      F3_BYTE, F3_UBYTE: size_mask = 4'b0001;
      F3_HALF, F3_UHALF: size_mask = 4'b0011;
      F3_WORD:           size_mask = 4'b1111;
      default:           size_mask = 4'b0000;
    endcase
  endfunction

  // Unsigned widths only make sense for loads.
  function automatic logic func3_illegal(input logic [2:0] func3, input logic we);
    func3_illegal = (size_mask(func3) == 4'b0000) || (we && func3[2]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store-side enables/data across two words
// and load-side shift plus sign/zero extension.
module mem_lane_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  input  logic [31:0] wdata,
  input  logic [63:0] rd64,
  output logic [7:0]  be8,
  output logic [63:0] wd64,
  output logic        split,
  output logic [31:0] rdata_ext
);

  logic [31:0] rd_shift;

  assign be8   = {4'b0000, size_mask(func3)} << off;
  assign wd64  = {32'b0, wdata} << {off, 3'b000};
  assign split = |be8[7:4];

  assign rd_shift = 32'(rd64 >> {off, 3'b000});

  always_comb begin
    rdata_ext = 32'b0;
    case (func3)
      F3_BYTE:  rdata_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_HALF:  rdata_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_WORD:  rdata_ext = rd_shift;
      F3_UBYTE: rdata_ext = {24'b0, rd_shift[7:0]};
      F3_UHALF: rdata_ext = {16'b0, rd_shift[15:0]};
      default:  rdata_ext = 32'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns one byte-addressed access into one or two
// word-aligned RAM cycles with byte enables, then returns extended load data.
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int MEM_BYTES = 512
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [2:0]                        req_func3,
  input  logic [31:0]                       req_addr,
  input  logic [31:0]                       req_wdata,
  output logic                              rsp_valid,
  output logic [31:0]                       rsp_rdata,
  output logic                              rsp_err,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [3:0]                        mem_be,
  output logic [$clog2(MEM_BYTES/4)-1:0]    mem_addr,
  output logic [31:0]                       mem_wdata,
  input  logic [31:0]                       mem_rdata
);

  localparam int ADDR_W  = $clog2(MEM_BYTES);
  localparam int WADDR_W = $clog2(MEM_BYTES / 4);

  lsu_state_e state_reg, state_next;

  logic               we_reg;
  logic [2:0]         func3_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [31:0]        wdata_reg;
  logic [31:0]        lo_buf_reg;

  logic [7:0]         be8;
  logic [63:0]        wd64;
  logic               split;
  logic [63:0]        rd64;
  logic [31:0]        rdata_ext;
  logic               illegal;
  logic [WADDR_W-1:0] lo_waddr;
  logic               accept;

  assign accept   = req_valid && (state_reg == LSU_IDLE);
  assign illegal  = func3_illegal(func3_reg, we_reg);
  assign lo_waddr = addr_reg[ADDR_W-1:2];
  // In DONE the RAM port carries the last word read (hi word when split).
  assign rd64     = split ? {mem_rdata, lo_buf_reg} : {32'b0, mem_rdata};

  mem_lane_align u_align (
    .off       (addr_reg[1:0]),
    .func3     (func3_reg),
    .wdata     (wdata_reg),
    .rd64      (rd64),
    .be8       (be8),
    .wd64      (wd64),
    .split     (split),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= LSU_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg     <= 1'b0;
      func3_reg  <= 3'b0;
      addr_reg   <= '0;
      wdata_reg  <= 32'b0;
      lo_buf_reg <= 32'b0;
    end else begin
      if (accept) begin
        we_reg    <= req_we;
        func3_reg <= req_func3;
        addr_reg  <= req_addr[ADDR_W-1:0];
        wdata_reg <= req_wdata;
      end
      // The lo word's read data arrives while the hi word is being issued.
      if (state_reg == LSU_HI && !we_reg) begin
        lo_buf_reg <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LSU_IDLE: begin
        if (req_valid) begin
          state_next = func3_illegal(req_func3, req_we) ? LSU_DONE : LSU_LO;
        end
      end
      LSU_LO:   state_next = split ? LSU_HI : LSU_DONE;
      LSU_HI:   state_next = LSU_DONE;
      LSU_DONE: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'b0;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0;
    mem_addr  = '0;
    mem_wdata = 32'b0;
    case (state_reg)
      LSU_IDLE: req_ready = 1'b1;
      LSU_LO: begin
        mem_en    = 1'b1;
        mem_we    = we_reg;
        mem_be    = be8[3:0];
        mem_addr  = lo_waddr;
        mem_wdata = wd64[31:0];
      end
      LSU_HI: begin
        mem_en    = 1'b1;
        mem_we    = we_reg;
        mem_be    = be8[7:4];
        mem_addr  = lo_waddr + 1'b1;
        mem_wdata = wd64[63:32];
      end
      LSU_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = illegal;
        rsp_rdata = (!we_reg && !illegal) ? rdata_ext : 32'b0;
      end
      default: ;
    endcase
  end

endmodule
